vec3_collect_fifo: RTL and testbench

Downstream stage of the 3x3 matrix-vector multiplier. Captures the staggered per-component results (x, then y, then z on consecutive cycles) into one 48-bit vector word. Buffers completed vectors in a small FIFO and presents them to the next stage over a valid/ready handshake. Reports back-pressure and protocol faults so the transform pipeline can be throttled or diagnosed.

---
 rtl/vec3_collect_fifo.sv | 157 +++++++++++++++
 tb/tb_vec3_collect_fifo.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/vec3_collect_fifo.sv
// rtl/vec3_collect_fifo.sv - collects staggered x/y/z result strobes into 48-bit vectors
// and buffers them in a small FIFO with a valid/ready output and sticky fault flags.
module vec3_collect_fifo #(
    parameter int DEPTH     = 4,
    parameter int AF_MARGIN = 3
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       donex,
    input  logic                       doney,
    input  logic                       donez,
    input  logic [15:0]                dx,
    input  logic [15:0]                dy,
    input  logic [15:0]                dz,
    input  logic                       clr_err,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [15:0]                out_x,
    output logic [15:0]                out_y,
    output logic [15:0]                out_z,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       almost_full,
    output logic                       overflow,
    output logic                       seq_err
);

    localparam int CW    = $clog2(DEPTH + 1);
    localparam int PW    = $clog2(DEPTH);
    localparam int AF_TH = DEPTH - AF_MARGIN;
    localparam logic [CW-1:0] FULL_C = CW'(DEPTH);

    typedef enum logic [1:0] {IDLE, HAVE_X, HAVE_XY} state_t;

    state_t        state;
    logic [15:0]   dx_held;
    logic [15:0]   dy_held;
    logic [47:0]   mem [DEPTH];
    logic [PW-1:0] wptr;
    logic [PW-1:0] rptr;

    logic          push_req;
    logic          seq_evt;
    logic          pop;
    logic          push_ok;
    logic [47:0]   push_data;
    logic [CW-1:0] count_n;
    logic [CW-1:0] remain;
    logic [PW-1:0] rptr_n;

    always_comb begin
        push_req = 1'b0;
        seq_evt  = 1'b0;
        case (state)
            IDLE:    seq_evt = doney | donez;
            HAVE_X:  seq_evt = ~doney | donex | donez;
            HAVE_XY: begin
                push_req = donez & ~doney;
                seq_evt  = ~donez | doney;
            end
            default: seq_evt = 1'b0;
        endcase
    end

    assign push_data = {dx_held, dy_held, dz};
    assign pop       = out_valid & out_ready;
    // A full FIFO still accepts a push when the head leaves on the same edge.
    assign push_ok   = push_req & ((count != FULL_C) | pop);
    assign remain    = count - CW'(pop);
    assign rptr_n    = pop ? rptr + PW'(1) : rptr;

    always_comb begin
        count_n = count;
        case ({push_ok, pop})
            2'b10:   count_n = count + CW'(1);
            2'b01:   count_n = count - CW'(1);
            default: count_n = count;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            dx_held <= '0;
            dy_held <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (donex) begin
                        dx_held <= dx;
                        state   <= HAVE_X;
                    end
                end
                HAVE_X: begin
                    if (doney && !donex && !donez) begin
                        dy_held <= dy;
                        state   <= HAVE_XY;
                    end else if (donex) begin
                        dx_held <= dx;
                        state   <= HAVE_X;
                    end else begin
                        state <= IDLE;
                    end
                end
                HAVE_XY: begin
                    // Completion or fault alike: a new x restarts collection immediately.
                    if (donex) begin
                        dx_held <= dx;
                        state   <= HAVE_X;
                    end else begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wptr] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wptr        <= '0;
            rptr        <= '0;
            count       <= '0;
            out_valid   <= 1'b0;
            out_x       <= '0;
            out_y       <= '0;
            out_z       <= '0;
            almost_full <= (AF_TH <= 0);
            overflow    <= 1'b0;
            seq_err     <= 1'b0;
        end else begin
            if (push_ok) begin
                wptr <= wptr + PW'(1);
            end
            rptr        <= rptr_n;
            count       <= count_n;
            out_valid   <= (count_n != '0);
            almost_full <= (int'(count_n) >= AF_TH);
            // The new head is the vector being pushed when nothing else remains.
            if (count_n != '0) begin
                if (remain == '0) begin
                    {out_x, out_y, out_z} <= push_data;
                end else begin
                    {out_x, out_y, out_z} <= mem[rptr_n];
                end
            end
            overflow <= (overflow & ~clr_err) | (push_req & ~push_ok);
            seq_err  <= (seq_err & ~clr_err) | seq_evt;
        end
    end

endmodule

// File: tb/tb_vec3_collect_fifo.sv
// tb/tb_vec3_collect_fifo.sv - randomized and directed self-checking bench for vec3_collect_fifo
// against a queue-based reference model.
module tb_vec3_collect_fifo;

    localparam int DEPTH     = 4;
    localparam int AF_MARGIN = 3;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        donex = 1'b0, doney = 1'b0, donez = 1'b0;
    logic [15:0] dx = '0, dy = '0, dz = '0;
    logic        clr_err = 1'b0;
    logic        out_ready = 1'b0;
    logic        out_valid;
    logic [15:0] out_x, out_y, out_z;
    logic [2:0]  count;
    logic        almost_full, overflow, seq_err;

    vec3_collect_fifo #(.DEPTH(DEPTH), .AF_MARGIN(AF_MARGIN)) dut (
        .clk(clk), .reset(reset),
        .donex(donex), .doney(doney), .donez(donez),
        .dx(dx), .dy(dy), .dz(dz),
        .clr_err(clr_err),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_x(out_x), .out_y(out_y), .out_z(out_z),
        .count(count), .almost_full(almost_full),
        .overflow(overflow), .seq_err(seq_err)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    logic [47:0] q[$];
    int          part;
    logic [15:0] px, py;
    bit          m_ovf, m_seq;
    logic [47:0] m_last;
    int          ph;

    task automatic chk(input string name, input logic [47:0] act, input logic [47:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        q.delete();
        part   = 0;
        px     = '0;
        py     = '0;
        m_ovf  = 1'b0;
        m_seq  = 1'b0;
        m_last = '0;
    endfunction

    function automatic void model_update();
        bit          err = 1'b0;
        bit          push = 1'b0;
        bit          pop;
        bit          acc;
        logic [47:0] vec = '0;
        pop = (q.size() > 0) && out_ready;
        case (part)
            0: begin
                err = doney || donez;
                if (donex) begin px = dx; part = 1; end
            end
            1: begin
                if (doney && !donex && !donez) begin
                    py = dy;
                    part = 2;
                end else begin
                    err = 1'b1;
                    if (donex) begin px = dx; part = 1; end else part = 0;
                end
            end
            default: begin
                if (donez && !doney) begin
                    push = 1'b1;
                    vec  = {px, py, dz};
                end else begin
                    err = 1'b1;
                end
                if (donex) begin px = dx; part = 1; end else part = 0;
            end
        endcase
        acc   = push && ((q.size() < DEPTH) || pop);
        m_ovf = (m_ovf && !clr_err) || (push && !acc);
        m_seq = (m_seq && !clr_err) || err;
        if (pop) void'(q.pop_front());
        if (acc) q.push_back(vec);
        if (q.size() > 0) m_last = q[0];
    endfunction

    task automatic check_all();
        chk("out_valid", 48'(out_valid), 48'(q.size() > 0));
        chk("count", 48'(count), 48'(q.size()));
        chk("almost_full", 48'(almost_full), 48'(q.size() >= DEPTH - AF_MARGIN));
        chk("overflow", 48'(overflow), 48'(m_ovf));
        chk("seq_err", 48'(seq_err), 48'(m_seq));
        chk("out_data", {out_x, out_y, out_z}, m_last);
    endtask

    task automatic step();
        @(posedge clk);
        model_update();
        @(negedge clk);
        check_all();
    endtask

    task automatic cyc(input bit sx, input bit sy, input bit sz,
                       input logic [15:0] vx, input logic [15:0] vy, input logic [15:0] vz,
                       input bit rdy, input bit clr);
        donex = sx; doney = sy; donez = sz;
        dx = vx; dy = vy; dz = vz;
        out_ready = rdy; clr_err = clr;
        step();
    endtask

    task automatic idle(input bit rdy, input bit clr);
        cyc(1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 16'h0, rdy, clr);
    endtask

    // Overlapping stream: each new x shares its cycle with the previous z.
    task automatic send_vecs(input int n, input logic [15:0] base, input bit rdy);
        for (int i = 0; i < n; i++) begin
            logic [15:0] b;
            b = base + 16'(3 * i);
            cyc(1'b1, 1'b0, i > 0, b, 16'h0, b - 16'd1, rdy, 1'b0);
            cyc(1'b0, 1'b1, 1'b0, 16'h0, b + 16'd1, 16'h0, rdy, 1'b0);
        end
        cyc(1'b0, 1'b0, 1'b1, 16'h0, 16'h0, base + 16'(3 * (n - 1) + 2), rdy, 1'b0);
    endtask

    initial begin
        model_reset();
        #1 reset = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_valid", 48'(out_valid), 48'h0);
        chk("rst_count", 48'(count), 48'h0);
        chk("rst_af", 48'(almost_full), 48'h0);
        chk("rst_data", {out_x, out_y, out_z}, 48'h0);
        reset = 1'b1;

        // single vector
        cyc(1'b1, 1'b0, 1'b0, 16'h3C00, 16'h0, 16'h0, 1'b1, 1'b0);
        chk("sv_count0", 48'(count), 48'h0);
        cyc(1'b0, 1'b1, 1'b0, 16'h0, 16'h4000, 16'h0, 1'b1, 1'b0);
        cyc(1'b0, 1'b0, 1'b1, 16'h0, 16'h0, 16'h4200, 1'b1, 1'b0);
        chk("sv_valid", 48'(out_valid), 48'h1);
        chk("sv_data", {out_x, out_y, out_z}, 48'h3C00_4000_4200);
        chk("sv_count1", 48'(count), 48'h1);
        idle(1'b1, 1'b0);
        chk("sv_count2", 48'(count), 48'h0);
        chk("sv_valid2", 48'(out_valid), 48'h0);
        chk("sv_hold", {out_x, out_y, out_z}, 48'h3C00_4000_4200);

        // fill and stall
        send_vecs(5, 16'h1000, 1'b0);
        chk("fs_count", 48'(count), 48'h4);
        chk("fs_af", 48'(almost_full), 48'h1);
        chk("fs_ovf", 48'(overflow), 48'h1);
        chk("fs_head", {out_x, out_y, out_z}, 48'h1000_1001_1002);
        repeat (5) idle(1'b1, 1'b0);
        chk("fs_drained", 48'(count), 48'h0);
        idle(1'b0, 1'b1);
        chk("fs_clr", 48'(overflow), 48'h0);

        // full with simultaneous pop
        send_vecs(4, 16'h2000, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 16'h2100, 16'h0, 16'h0, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 1'b0, 16'h0, 16'h2101, 16'h0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b1, 16'h0, 16'h0, 16'h2102, 1'b1, 1'b0);
        chk("sp_count", 48'(count), 48'h4);
        chk("sp_ovf", 48'(overflow), 48'h0);
        chk("sp_head", {out_x, out_y, out_z}, 48'h2003_2004_2005);
        repeat (5) idle(1'b1, 1'b0);

        // sequence faults
        cyc(1'b0, 1'b1, 1'b0, 16'h0, 16'h0BAD, 16'h0, 1'b1, 1'b0);
        chk("sq_y_alone", 48'(seq_err), 48'h1);
        chk("sq_nopush", 48'(count), 48'h0);
        idle(1'b1, 1'b1);
        chk("sq_clr", 48'(seq_err), 48'h0);
        cyc(1'b1, 1'b0, 1'b0, 16'h3000, 16'h0, 16'h0, 1'b1, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 16'h3010, 16'h0, 16'h0, 1'b1, 1'b0);
        chk("sq_xx", 48'(seq_err), 48'h1);
        cyc(1'b0, 1'b1, 1'b0, 16'h0, 16'h3011, 16'h0, 1'b1, 1'b0);
        cyc(1'b0, 1'b0, 1'b1, 16'h0, 16'h0, 16'h3012, 1'b1, 1'b0);
        chk("sq_restart", {out_x, out_y, out_z}, 48'h3010_3011_3012);
        idle(1'b1, 1'b1);

        // pointer wrap
        send_vecs(20, 16'h4000, 1'b1);
        chk("wr_seq", 48'(seq_err), 48'h0);
        chk("wr_ovf", 48'(overflow), 48'h0);
        repeat (2) idle(1'b1, 1'b0);

        // randomized traffic
        ph = 0;
        for (int i = 0; i < 1500; i++) begin
            bit sx, sy, sz;
            sx = 1'b0; sy = 1'b0; sz = 1'b0;
            if ($urandom_range(0, 9) == 0) begin
                {sx, sy, sz} = 3'($urandom);
                ph = sx ? 1 : 0;
            end else begin
                case (ph)
                    0: begin sx = ($urandom_range(0, 3) != 0); ph = sx ? 1 : 0; end
                    1: begin sy = 1'b1; ph = 2; end
                    default: begin sz = 1'b1; sx = 1'($urandom_range(0, 1)); ph = sx ? 1 : 0; end
                endcase
            end
            cyc(sx, sy, sz, 16'($urandom), 16'($urandom), 16'($urandom),
                $urandom_range(0, 9) < ((i < 750) ? 3 : 8), $urandom_range(0, 29) == 0);
        end
        idle(1'b1, 1'b1);

        // asynchronous reset mid-operation
        send_vecs(3, 16'h5000, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 16'h5100, 16'h0, 16'h0, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 1'b0, 16'h0, 16'h5101, 16'h0, 1'b0, 1'b0);
        chk("ar_pre", 48'(count), 48'h3);
        idle(1'b0, 1'b0);
        #2 reset = 1'b0;
        #1;
        chk("ar_valid", 48'(out_valid), 48'h0);
        chk("ar_count", 48'(count), 48'h0);
        chk("ar_data", {out_x, out_y, out_z}, 48'h0);
        chk("ar_flags", {45'h0, almost_full, overflow, seq_err}, 48'h0);
        model_reset();
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        send_vecs(1, 16'h6000, 1'b1);
        chk("ar_fresh", {out_x, out_y, out_z}, 48'h6000_6001_6002);
        chk("ar_fresh_cnt", 48'(count), 48'h1);
        repeat (2) idle(1'b1, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
